// File: rtl/ctrl_data_fifo.sv
// ctrl_data_fifo: independent data and ctrl queues, popped together as one {ctrl, data} pair
module ctrl_data_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int CTRL_WIDTH   = 32,
   parameter int DEPTH        = 256,
   parameter int READ_LATENCY = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [DATA_WIDTH-1:0]            din_data,
   input  logic                             data_valid,
   output logic                             data_ready,
   input  logic [CTRL_WIDTH-1:0]            ctrl_data,
   input  logic                             ctrl_valid,
   output logic                             ctrl_ready,
   output logic [CTRL_WIDTH+DATA_WIDTH-1:0] dout,
   output logic                             valid,
   input  logic                             ready,
   input  logic                             shift_out,
   output logic                             empty,
   output logic                             data_overflow,
   output logic                             data_underflow,
   output logic                             ctrl_overflow,
   output logic                             ctrl_underflow
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [CTRL_WIDTH-1:0] ctrl_mem [DEPTH];
   logic [AW:0] data_wr, data_rd, ctrl_wr, ctrl_rd;
   logic run, data_full, data_empty, ctrl_full, ctrl_empty, data_push, ctrl_push, pop;
   logic [CTRL_WIDTH+DATA_WIDTH-1:0] head;
   // run holds both readies low in reset and releases them on the first edge afterwards
   always_comb begin
      data_full  = data_wr == {~data_rd[AW], data_rd[AW-1:0]};
      ctrl_full  = ctrl_wr == {~ctrl_rd[AW], ctrl_rd[AW-1:0]};
      data_empty = data_wr == data_rd;
      ctrl_empty = ctrl_wr == ctrl_rd;
      data_ready = run && !data_full;
      ctrl_ready = run && !ctrl_full;
      data_push  = data_valid && data_ready;
      ctrl_push  = ctrl_valid && ctrl_ready;
      empty      = data_empty || ctrl_empty;
      pop        = shift_out && ready && !empty;
      head       = {ctrl_mem[ctrl_rd[AW-1:0]], data_mem[data_rd[AW-1:0]]};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         run            <= 1'b0;
         data_wr        <= '0;
         data_rd        <= '0;
         ctrl_wr        <= '0;
         ctrl_rd        <= '0;
         data_overflow  <= 1'b0;
         data_underflow <= 1'b0;
         ctrl_overflow  <= 1'b0;
         ctrl_underflow <= 1'b0;
      end else begin
         run            <= 1'b1;
         data_wr        <= data_wr + (AW+1)'(data_push);
         ctrl_wr        <= ctrl_wr + (AW+1)'(ctrl_push);
         data_rd        <= data_rd + (AW+1)'(pop);
         ctrl_rd        <= ctrl_rd + (AW+1)'(pop);
         data_overflow  <= data_valid && data_full;
         data_underflow <= shift_out && data_empty;
         ctrl_overflow  <= ctrl_valid && ctrl_full;
         ctrl_underflow <= shift_out && ctrl_empty;
      end
   always_ff @(posedge clk) begin
      if (data_push) data_mem[data_wr[AW-1:0]] <= din_data;
      if (ctrl_push) ctrl_mem[ctrl_wr[AW-1:0]] <= ctrl_data;
   end
   if (READ_LATENCY == 0) begin : g_comb
      assign dout  = empty ? '0 : head;
      assign valid = !empty;
   end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            dout  <= '0;
            valid <= 1'b0;
         end else begin
            valid <= pop;
            if (pop) dout <= head;
         end
   end
endmodule

// File: tb/tb_ctrl_data_fifo.sv
// tb_ctrl_data_fifo: randomized scoreboard bench for ctrl_data_fifo against a queue-level model
module tb_ctrl_data_fifo;
   localparam int DW = 32, CW = 16, DEPTH = 16, PW = CW + DW;
   logic clk = 1'b0, rst_n = 1'b1;
   logic [DW-1:0] din_data = '0;
   logic [CW-1:0] ctrl_data = '0;
   logic data_valid = 1'b0, ctrl_valid = 1'b0, ready = 1'b0, shift_out = 1'b0;
   logic data_ready, ctrl_ready, valid, empty;
   logic data_overflow, data_underflow, ctrl_overflow, ctrl_underflow;
   logic [PW-1:0] dout;

   ctrl_data_fifo #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(DEPTH), .READ_LATENCY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .din_data(din_data), .data_valid(data_valid), .data_ready(data_ready),
      .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
      .dout(dout), .valid(valid), .ready(ready), .shift_out(shift_out), .empty(empty),
      .data_overflow(data_overflow), .data_underflow(data_underflow),
      .ctrl_overflow(ctrl_overflow), .ctrl_underflow(ctrl_underflow)
   );

   always #5 clk = ~clk;

   // reference model: plain queues of what each FIFO should hold, plus expected pop results
   logic [DW-1:0] mdq[$];
   logic [CW-1:0] mcq[$];
   logic [PW-1:0] sb[$];
   logic e_run = 1'b0, e_v = 1'b0;
   logic e_dovf = 1'b0, e_dunf = 1'b0, e_covf = 1'b0, e_cunf = 1'b0;
   logic [PW-1:0] held = '0;
   int n_chk = 0, n_fail = 0, to_count = 0, to_seen = 0;

   // stimulus sources
   logic [DW-1:0] d_src[$];
   logic [CW-1:0] c_src[$];
   int d_rate = 0, c_rate = 0, pop_rate = 0, rdy_rate = 100;

   task automatic model_reset();
      mdq.delete();
      mcq.delete();
      e_run  <= 1'b0;
      e_v    <= 1'b0;
      e_dovf <= 1'b0;
      e_dunf <= 1'b0;
      e_covf <= 1'b0;
      e_cunf <= 1'b0;
   endtask

   task automatic model_edge();
      bit dp, cp, p;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      dp = data_valid && e_run && mdq.size() < DEPTH;
      cp = ctrl_valid && e_run && mcq.size() < DEPTH;
      p  = shift_out && ready && mdq.size() != 0 && mcq.size() != 0;
      e_dovf <= data_valid && mdq.size() == DEPTH;
      e_covf <= ctrl_valid && mcq.size() == DEPTH;
      e_dunf <= shift_out && mdq.size() == 0;
      e_cunf <= shift_out && mcq.size() == 0;
      e_v    <= p;
      e_run  <= 1'b1;
      if (p) begin
         d = mdq.pop_front();
         c = mcq.pop_front();
         sb.push_back({c, d});
      end
      if (dp) mdq.push_back(din_data);
      if (cp) mcq.push_back(ctrl_data);
   endtask

   always @(posedge clk or negedge rst_n)
      if (!rst_n) model_reset();
      else model_edge();

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor_sample();
      if (!rst_n) begin
         sb.delete();
         held = '0;
      end
      chk("empty", 64'(empty), 64'(mdq.size() == 0 || mcq.size() == 0));
      chk("data_ready", 64'(data_ready), 64'(e_run && mdq.size() < DEPTH));
      chk("ctrl_ready", 64'(ctrl_ready), 64'(e_run && mcq.size() < DEPTH));
      chk("valid", 64'(valid), 64'(e_v));
      chk("data_overflow", 64'(data_overflow), 64'(e_dovf));
      chk("data_underflow", 64'(data_underflow), 64'(e_dunf));
      chk("ctrl_overflow", 64'(ctrl_overflow), 64'(e_covf));
      chk("ctrl_underflow", 64'(ctrl_underflow), 64'(e_cunf));
      if (valid) begin
         chk("scoreboard_entry", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) held = sb.pop_front();
      end
      chk("dout", 64'(dout), 64'(held));
      if (to_count != to_seen) begin
         chk("drain_timeout", 64'(to_count), 64'(to_seen));
         to_seen = to_count;
      end
   endtask

   always @(negedge clk) monitor_sample();

   task automatic step();
      bit da, ca;
      @(negedge clk);
      da = data_valid && data_ready;
      ca = ctrl_valid && ctrl_ready;
      @(posedge clk);
      #1;
      if (da) void'(d_src.pop_front());
      if (ca) void'(c_src.pop_front());
      data_valid = d_src.size() != 0 && $urandom_range(99) < d_rate;
      ctrl_valid = c_src.size() != 0 && $urandom_range(99) < c_rate;
      if (d_src.size() != 0) din_data = d_src[0];
      else din_data = $urandom;
      if (c_src.size() != 0) ctrl_data = c_src[0];
      else ctrl_data = CW'($urandom);
      shift_out = $urandom_range(99) < pop_rate;
      ready     = $urandom_range(99) < rdy_rate;
   endtask

   task automatic drain(input int max_cycles);
      int k = 0;
      while (k < max_cycles && !(d_src.size() == 0 && c_src.size() == 0 &&
             (mdq.size() == 0 || mcq.size() == 0) && !e_v)) begin
         step();
         k++;
      end
      if (k >= max_cycles) to_count++;
      step();
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      #2;
      do_reset();
      repeat (3) step();
      // data only, then a pop request that must be refused
      d_rate = 100; c_rate = 100; pop_rate = 0; rdy_rate = 100;
      d_src.push_back(32'hAAAA0001);
      repeat (3) step();
      pop_rate = 100;
      repeat (3) step();
      pop_rate = 0;
      do_reset();
      // ctrl first, data three cycles later
      pop_rate = 100;
      c_src.push_back(16'h0010);
      repeat (3) step();
      d_src.push_back(32'hDEADBEEF);
      drain(50);
      do_reset();
      // staggered burst of 8 pairs
      for (int i = 0; i < 8; i++) begin
         c_src.push_back(CW'(i));
         d_src.push_back(DW'(100 + i));
      end
      d_rate = 60; c_rate = 35; pop_rate = 100; rdy_rate = 100;
      drain(200);
      // fill the data queue and hold data_valid against it
      for (int i = 0; i < DEPTH + 4; i++) d_src.push_back($urandom);
      d_rate = 100; c_rate = 100; pop_rate = 0;
      repeat (DEPTH + 8) step();
      for (int i = 0; i < DEPTH + 4; i++) c_src.push_back(CW'($urandom));
      pop_rate = 100;
      drain(400);
      // back-to-back push/pop through several wraps, reset mid-stream
      for (int i = 0; i < 3 * DEPTH; i++) begin
         d_src.push_back($urandom);
         c_src.push_back(CW'($urandom));
      end
      repeat (DEPTH + 5) step();
      #3 rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      drain(1000);
      // random soak with uneven channel rates
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 60; i++) begin
            d_src.push_back($urandom);
            c_src.push_back(CW'($urandom));
         end
         d_rate   = int'($urandom_range(100, 10));
         c_rate   = int'($urandom_range(100, 10));
         pop_rate = int'($urandom_range(100, 20));
         rdy_rate = int'($urandom_range(100, 30));
         if (r == 2) pop_rate = 5;
         drain(5000);
      end
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end
endmodule
